mem_lsu: RTL
============

# mem_lsu

Load/store unit of the MEM stage. It consumes the execute stage's memory request (aluop, effective address, store data) and drives a single-outstanding req/ack data-memory bus, holding the pipeline stalled until the access completes. It returns the aligned, extended load data or passes the ALU result through to write-back.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (fixed at 32; byte strobes are 4 bits)

Ports (clock and reset first):
- `clk` in 1: the only clock
- `rst` in 1: asynchronous, active-high reset
- `ex_valid_i` in 1: execute stage presents an instruction
- `ex_aluop_i` in 8: aluop code
- `ex_addr_i` in 32: effective address
- `ex_wdata_i` in 32: store data (rj/rd source)
- `ex_result_i` in 32: ALU result for non-memory ops
- `ex_wd_i` in 5: destination register
- `ex_wreg_i` in 1: register write enable
- `ex_excp_i` in 1: upstream exception already raised
- `flush_i` in 1: pipeline flush
- `stallreq_o` out 1: stall request to the pipeline controller
- `data_req_o` out 1: bus request
- `data_we_o` out 1: store
- `data_wstrb_o` out 4: byte strobes
- `data_addr_o` out 32: word-aligned address
- `data_wdata_o` out 32: lane-replicated store data
- `data_ack_i` in 1: bus completion; read data valid on the same cycle
- `data_rdata_i` in 32: read word
- `wb_valid_o` out 1: write-back result valid, one-cycle pulse
- `wb_wd_o` out 5: destination register
- `wb_wreg_o` out 1: register write enable
- `wb_wdata_o` out 32: write-back data
- `wb_excp_o` out 1: upstream exception passed through
- `wb_ale_o` out 1: address-misaligned exception

## Operation
- **Op classes:** LD_B, LD_H, LD_W, LD_BU, LD_HU, ST_B, ST_H and ST_W are memory ops. Every other aluop is a pass-through.
- **FSM states:** IDLE, REQ, RESP.
- **Start condition:** `ex_valid_i & !flush_i` while in IDLE.
  - Memory op, no upstream exception, aligned address: latch the request and go to REQ.
  - Anything else: latch the write-back fields and go to RESP.
- **REQ:**
  - `data_req_o`=1. Address, we, strb and wdata are registered and held stable until ack.
  - On `data_ack_i`, capture `data_rdata_i` and go to RESP.
- **RESP:** `wb_valid_o`=1 for one cycle, then IDLE.
- **Misalignment:**
  - Halfword ops with `addr[0]`≠0 and word ops with `addr[1:0]`≠0 are misaligned.
  - A misaligned access issues no bus request; it sets `wb_ale_o`=1 and forces `wb_wreg_o`=0.
- **Upstream exception:** when `ex_excp_i`=1, no bus access is made; `wb_excp_o`=1 and `wb_wreg_o`=0.
- **Bus address:** `{addr[31:2],2'b00}`.
- **Store formatting:**
  - ST_B: strb = `4'b0001<<addr[1:0]`, wdata = `{4{wdata[7:0]}}`.
  - ST_H: strb = `4'b0011<<{addr[1],1'b0}`, wdata = `{2{wdata[15:0]}}`.
  - ST_W: strb = `4'b1111`.
  - Loads drive strb = 0.
  - Stores write-back with `wb_wreg_o`=0.
- **Load formatting:**
  - Byte lane is `addr[1:0]`; half lane is `addr[1]`.
  - LD_B and LD_H sign-extend.
  - LD_BU and LD_HU zero-extend.
- **Pass-through:** `wb_wdata_o` = `ex_result_i`; `wb_wreg_o` = `ex_wreg_i`.
- **Flush:**
  - In IDLE: no start.
  - In REQ: the request is held until ack (the bus cannot abort), then the result is discarded. No `wb_valid_o` is produced and the FSM returns to IDLE.
  - In RESP: `wb_valid_o` is suppressed.
- **Stall:** `stallreq_o` = (state==REQ) | (IDLE & start of a memory op). It is deasserted in RESP.

## Timing
- **Reset:** all outputs are 0 and the state is IDLE, immediately and asynchronously. `data_req_o` drops mid-transaction. An ack arriving in IDLE is ignored.
- **Memory op:** accepted in cycle N; `data_req_o` is high from N+1.
- **Ack:** the earliest ack is at N+1. The ack is registered, so `wb_valid_o` comes 1 cycle after the ack, i.e. at N+2 at the earliest.
- **Pass-through, misaligned or excepted op:** `wb_valid_o` at N+1, with no stall.
- **Request hold:** `data_req_o` stays asserted indefinitely while ack is low; there is no timeout.
- **Single outstanding:** exactly one access is in flight. A new start is accepted only in IDLE, and the cycle after RESP is the earliest next acceptance.
- **Write-back fields:** `wb_*` fields are valid only while `wb_valid_o`=1 and hold their values otherwise.

## Structure
- The load/store aluop codes and the LSU state encoding go in the shared `defines.v`, next to the existing aluop constants.
- One combinational sub-module, `lsu_align`:
  - Inputs: aluop, `addr[1:0]`, store data, read word.
  - Outputs: strb, replicated wdata, extended load data, misaligned flag.
- `mem_lsu` keeps the FSM, the request registers and the write-back registers.

## Test plan
- **Byte load, lane 3, sign-extend:** LD_B at 0x1003, rdata=0x80FF_1234, ack one cycle after req → `data_addr_o`=0x1000, `wb_wdata_o`=0xFFFF_FF80, `wb_wreg_o`=1, stall for 2 cycles.
- **Halfword store, upper half:** ST_H at 0x2002, wdata=0xAAAA_BEEF → strb=0xC, `data_wdata_o`=0xBEEF_BEEF, `we`=1, `wb_wreg_o`=0.
- **Misaligned word load:** LD_W at 0x3001 → `data_req_o` never rises, `wb_ale_o`=1 at N+1, `wb_wreg_o`=0.
- **Flush during wait:** LD_HU at 0x4002, ack held low 5 cycles, `flush_i` pulsed in the 2nd cycle → req held until ack, no `wb_valid_o`, FSM back in IDLE.
- **Pass-through:** ADD with result 0x0000_0007 and upstream exception set → no bus access, `wb_valid_o` at N+1 with `wb_excp_o`=1 and `wb_wreg_o`=0. The same ADD without the exception → `wb_wdata_o`=7, `wb_wreg_o`=1.
- **Reset mid-transaction:** `rst` asserted while in REQ → `data_req_o`=0 in the same cycle. A late ack after reset release produces no `wb_valid_o`.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the MEM-stage load/store unit.
//   - aluop codes for the memory ops and a few ordinary ALU ops
//   - LSU state encoding
//   - helper functions that classify an aluop as load / store / memory op
package mem_lsu_pkg;

    // Ordinary ALU ops. Anything that is not a memory op is a pass-through.
    localparam logic [7:0] ALUOP_NOP   = 8'h00;
    localparam logic [7:0] ALUOP_ADD   = 8'h01;
    localparam logic [7:0] ALUOP_SUB   = 8'h02;
    localparam logic [7:0] ALUOP_AND   = 8'h03;
    localparam logic [7:0] ALUOP_OR    = 8'h04;

    // Loads
    localparam logic [7:0] ALUOP_LD_B  = 8'h30;
    localparam logic [7:0] ALUOP_LD_H  = 8'h31;
    localparam logic [7:0] ALUOP_LD_W  = 8'h32;
    localparam logic [7:0] ALUOP_LD_BU = 8'h33;
    localparam logic [7:0] ALUOP_LD_HU = 8'h34;

    // Stores
    localparam logic [7:0] ALUOP_ST_B  = 8'h38;
    localparam logic [7:0] ALUOP_ST_H  = 8'h39;
    localparam logic [7:0] ALUOP_ST_W  = 8'h3A;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_t;

    function automatic logic is_load(input logic [7:0] op);
        return (op == ALUOP_LD_B)  || (op == ALUOP_LD_H) || (op == ALUOP_LD_W) ||
               (op == ALUOP_LD_BU) || (op == ALUOP_LD_HU);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == ALUOP_ST_B) || (op == ALUOP_ST_H) || (op == ALUOP_ST_W);
    endfunction

    function automatic logic is_mem_op(input logic [7:0] op);
        return is_load(op) || is_store(op);
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// lsu_align: purely combinational lane steering for the load/store unit.
//   aluop     in  8  : memory aluop (non-memory ops produce neutral outputs)
//   addr_lo   in  2  : low address bits selecting the byte / half lane
//   wdata     in  32 : raw store data from the register file
//   rdata     in  32 : word returned by the data bus
//   strb      out 4  : byte strobes for stores (0 for loads)
//   wdata_rep out 32 : store data replicated across all lanes
//   load_data out 32 : selected lane, sign- or zero-extended
//   misaligned out 1 : halfword/word access not naturally aligned
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  strb,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data,
    output logic        misaligned
);

    // Split the read word into byte lanes so lane selection is a plain index.
    logic [7:0] rbytes [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rbytes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rbytes[addr_lo];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        strb       = 4'b0000;
        wdata_rep  = wdata;
        load_data  = rdata;
        misaligned = 1'b0;
        case (aluop)
            ALUOP_LD_B: begin
                load_data = {{24{byte_sel[7]}}, byte_sel};
            end
            ALUOP_LD_BU: begin
                load_data = {24'h000000, byte_sel};
            end
            ALUOP_LD_H: begin
                misaligned = addr_lo[0];
                load_data  = {{16{half_sel[15]}}, half_sel};
            end
            ALUOP_LD_HU: begin
                misaligned = addr_lo[0];
                load_data  = {16'h0000, half_sel};
            end
            ALUOP_LD_W: begin
                misaligned = |addr_lo;
            end
            ALUOP_ST_B: begin
                strb      = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            ALUOP_ST_H: begin
                misaligned = addr_lo[0];
                strb       = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep  = {2{wdata[15:0]}};
            end
            ALUOP_ST_W: begin
                misaligned = |addr_lo;
                strb       = 4'b1111;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with a single-outstanding req/ack bus.
//   clk, rst          : clock, asynchronous active-high reset
//   ex_*_i            : request from the execute stage (valid, aluop, address,
//                       store data, ALU result, dest reg, write enable, exception)
//   flush_i           : pipeline flush
//   stallreq_o        : stall while a bus access is being started or is in flight
//   data_*            : data-memory bus (req/we/strb/addr/wdata out, ack/rdata in)
//   wb_*_o            : write-back result, wb_valid_o is a one-cycle pulse
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid_i,
    input  logic [7:0]        ex_aluop_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic [DATA_W-1:0] ex_result_i,
    input  logic [4:0]        ex_wd_i,
    input  logic              ex_wreg_i,
    input  logic              ex_excp_i,
    input  logic              flush_i,
    output logic              stallreq_o,
    output logic              data_req_o,
    output logic              data_we_o,
    output logic [3:0]        data_wstrb_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_ack_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_wd_o,
    output logic              wb_wreg_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic              wb_excp_o,
    output logic              wb_ale_o
);

    lsu_state_t        state_reg;

    // Request context kept while the bus access is in flight.
    logic [7:0]        req_aluop_reg;
    logic [1:0]        req_addr_lo_reg;
    logic [4:0]        req_wd_reg;
    logic              req_wreg_reg;
    logic              flushed_reg;

    logic              data_req_reg;
    logic              data_we_reg;
    logic [3:0]        data_wstrb_reg;
    logic [ADDR_W-1:0] data_addr_reg;
    logic [DATA_W-1:0] data_wdata_reg;

    logic              wb_valid_reg;
    logic [4:0]        wb_wd_reg;
    logic              wb_wreg_reg;
    logic [DATA_W-1:0] wb_wdata_reg;
    logic              wb_excp_reg;
    logic              wb_ale_reg;

    logic              in_idle;
    logic              start;
    logic              mem_op;
    logic              go_bus;

    logic [7:0]        align_op;
    logic [1:0]        align_lo;
    logic [3:0]        align_strb;
    logic [31:0]       align_wdata;
    logic [31:0]       align_load;
    logic              align_mis;

    // The aligner is shared: in IDLE it formats the incoming request, while
    // waiting on the bus it extends the returning word for the latched op.
    assign in_idle  = (state_reg == LSU_IDLE);
    assign align_op = in_idle ? ex_aluop_i : req_aluop_reg;
    assign align_lo = in_idle ? ex_addr_i[1:0] : req_addr_lo_reg;

    lsu_align u_align (
        .aluop      (align_op),
        .addr_lo    (align_lo),
        .wdata      (ex_wdata_i),
        .rdata      (data_rdata_i),
        .strb       (align_strb),
        .wdata_rep  (align_wdata),
        .load_data  (align_load),
        .misaligned (align_mis)
    );

    assign start  = in_idle & ex_valid_i & ~flush_i;
    assign mem_op = is_mem_op(ex_aluop_i);
    // Only a clean, aligned memory op actually touches the bus.
    assign go_bus = start & mem_op & ~ex_excp_i & ~align_mis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= LSU_IDLE;
            req_aluop_reg   <= 8'h00;
            req_addr_lo_reg <= 2'b00;
            req_wd_reg      <= 5'd0;
            req_wreg_reg    <= 1'b0;
            flushed_reg     <= 1'b0;
            data_req_reg    <= 1'b0;
            data_we_reg     <= 1'b0;
            data_wstrb_reg  <= 4'b0000;
            data_addr_reg   <= '0;
            data_wdata_reg  <= '0;
            wb_valid_reg    <= 1'b0;
            wb_wd_reg       <= 5'd0;
            wb_wreg_reg     <= 1'b0;
            wb_wdata_reg    <= '0;
            wb_excp_reg     <= 1'b0;
            wb_ale_reg      <= 1'b0;
        end else begin
            case (state_reg)
                LSU_IDLE: begin
                    if (go_bus) begin
                        req_aluop_reg   <= ex_aluop_i;
                        req_addr_lo_reg <= ex_addr_i[1:0];
                        req_wd_reg      <= ex_wd_i;
                        req_wreg_reg    <= ex_wreg_i;
                        flushed_reg     <= 1'b0;
                        data_req_reg    <= 1'b1;
                        data_we_reg     <= is_store(ex_aluop_i);
                        data_wstrb_reg  <= align_strb;
                        data_addr_reg   <= {ex_addr_i[ADDR_W-1:2], 2'b00};
                        data_wdata_reg  <= align_wdata;
                        state_reg       <= LSU_REQ;
                    end else if (start) begin
                        // Pass-through, misaligned or already-excepted op:
                        // answer directly, never writing a register on a fault.
                        wb_valid_reg <= 1'b1;
                        wb_wd_reg    <= ex_wd_i;
                        wb_wreg_reg  <= ex_wreg_i & ~ex_excp_i & ~(mem_op & align_mis)
                                        & ~is_store(ex_aluop_i);
                        wb_wdata_reg <= ex_result_i;
                        wb_excp_reg  <= ex_excp_i;
                        wb_ale_reg   <= mem_op & align_mis;
                        state_reg    <= LSU_RESP;
                    end
                end
                LSU_REQ: begin
                    // The bus cannot abort, so a flush only marks the result
                    // to be dropped once the ack arrives.
                    if (flush_i) begin
                        flushed_reg <= 1'b1;
                    end
                    if (data_ack_i) begin
                        data_req_reg <= 1'b0;
                        if (flushed_reg | flush_i) begin
                            state_reg <= LSU_IDLE;
                        end else begin
                            wb_valid_reg <= 1'b1;
                            wb_wd_reg    <= req_wd_reg;
                            wb_wreg_reg  <= req_wreg_reg & is_load(req_aluop_reg);
                            wb_wdata_reg <= is_load(req_aluop_reg) ? align_load : '0;
                            wb_excp_reg  <= 1'b0;
                            wb_ale_reg   <= 1'b0;
                            state_reg    <= LSU_RESP;
                        end
                    end
                end
                LSU_RESP: begin
                    wb_valid_reg <= 1'b0;
                    state_reg    <= LSU_IDLE;
                end
                default: begin
                    state_reg <= LSU_IDLE;
                end
            endcase
        end
    end

    // Stall covers the accepting cycle of a bus op plus the whole wait.
    assign stallreq_o   = ~rst & ((state_reg == LSU_REQ) | go_bus);

    assign data_req_o   = data_req_reg;
    assign data_we_o    = data_we_reg;
    assign data_wstrb_o = data_wstrb_reg;
    assign data_addr_o  = data_addr_reg;
    assign data_wdata_o = data_wdata_reg;

    // A flush arriving while the result is presented cancels it in that cycle.
    assign wb_valid_o   = wb_valid_reg & ~flush_i;
    assign wb_wd_o      = wb_wd_reg;
    assign wb_wreg_o    = wb_wreg_reg;
    assign wb_wdata_o   = wb_wdata_reg;
    assign wb_excp_o    = wb_excp_reg;
    assign wb_ale_o     = wb_ale_reg;

endmodule
